// File: rtl/iodelay_pkg.sv
// Shared types and constants for the IODELAY tap controller.
package iodelay_pkg;

  localparam int               TAP_W   = 7;
  localparam logic [TAP_W-1:0] TAP_MAX = 7'd127;

  typedef enum logic [2:0] {
    LOAD,
    IDLE,
    SETUP,
    STEP_LO,
    STEP_HI,
    DONE,
    ERR
  } state_e;

  // One tap in the given direction (dn=1 means decrement), clamped at both ends.
  function automatic logic [TAP_W-1:0] tap_step(input logic [TAP_W-1:0] tap,
                                                input logic             dn);
    logic [TAP_W-1:0] res;
    if (dn) res = (tap == '0)     ? tap : tap - 7'd1;
    else    res = (tap == TAP_MAX) ? tap : tap + 7'd1;
    return res;
  endfunction

endpackage

// File: rtl/sync2_ff.sv
// Two-flop synchroniser for the asynchronous IODELAY DF flag.
module sync2_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/iodelay_tap_ctrl.sv
// Steps one IODELAY to a requested absolute tap via SDTAP/SETN/VALUE and
// keeps a shadow copy of the current tap.
module iodelay_tap_ctrl
  import iodelay_pkg::*;
#(
  parameter int STATIC_DLY = 96,
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_LO   = 2,
  parameter int PULSE_HI   = 2,
  parameter int LOAD_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_load,
  input  logic [TAP_W-1:0] req_tap,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [TAP_W-1:0] cur_tap,
  input  logic             df_i,
  output logic             sdtap_o,
  output logic             setn_o,
  output logic             value_o
);

  localparam int MAX_AB  = (SETUP_CYC > PULSE_LO) ? SETUP_CYC : PULSE_LO;
  localparam int MAX_CD  = (PULSE_HI > LOAD_CYC) ? PULSE_HI : LOAD_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LO_LD    = CNT_W'(PULSE_LO - 1);
  localparam logic [CNT_W-1:0] HI_LD    = CNT_W'(PULSE_HI - 1);
  localparam logic [CNT_W-1:0] LOAD_LD  = CNT_W'(LOAD_CYC - 1);
  localparam logic [TAP_W-1:0] STATIC_TAP = TAP_W'(STATIC_DLY);

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] tmr_q,     tmr_d;
  logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
  logic [TAP_W-1:0] target_q,  target_d;
  logic             setn_q,    setn_d;
  logic             pwrup_q,   pwrup_d;
  logic             df_sync;
  logic             tmr_done;
  logic             dir_dn;

  sync2_ff u_df_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (df_i),
    .q_o   (df_sync)
  );

  assign tmr_done = (tmr_q == '0);
  assign dir_dn   = (target_q < cur_tap_q);

  // State register; reset re-enters LOAD so the IODELAY is resynchronised to the static tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      tmr_q     <= LOAD_LD;
      cur_tap_q <= STATIC_TAP;
      target_q  <= STATIC_TAP;
      setn_q    <= 1'b0;
      pwrup_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cur_tap_q <= cur_tap_d;
      target_q  <= target_d;
      setn_q    <= setn_d;
      pwrup_q   <= pwrup_d;
    end
  end

  // Next-state logic; the shadow tap moves on entry to STEP_LO, i.e. with the VALUE falling edge.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cur_tap_d = cur_tap_q;
    target_d  = target_q;
    setn_d    = setn_q;
    pwrup_d   = pwrup_q;
    unique case (state_q)
      LOAD: begin
        if (tmr_done) begin
          cur_tap_d = STATIC_TAP;
          state_d   = pwrup_q ? IDLE : DONE;
          pwrup_d   = 1'b0;
        end else begin
          tmr_d = tmr_q - CNT_W'(1);
        end
      end
      IDLE: begin
        if (req_valid) begin
          if (req_load) begin
            state_d = LOAD;
            tmr_d   = LOAD_LD;
          end else if (req_tap == cur_tap_q) begin
            state_d = DONE;
          end else begin
            setn_d   = (req_tap < cur_tap_q);
            target_d = req_tap;
            state_d  = SETUP;
            tmr_d    = SETUP_LD;
          end
        end
      end
      SETUP: begin
        if (tmr_done) begin
          state_d   = STEP_LO;
          tmr_d     = LO_LD;
          cur_tap_d = tap_step(cur_tap_q, setn_q);
        end else begin
          tmr_d = tmr_q - CNT_W'(1);
        end
      end
      STEP_LO: begin
        if (tmr_done) begin
          state_d = STEP_HI;
          tmr_d   = HI_LD;
        end else begin
          tmr_d = tmr_q - CNT_W'(1);
        end
      end
      STEP_HI: begin
        if (tmr_done) begin
          if (df_sync) begin
            state_d = ERR;
          end else if (cur_tap_q == target_q) begin
            state_d = DONE;
          end else if (dir_dn != setn_q) begin
            setn_d  = dir_dn;
            state_d = SETUP;
            tmr_d   = SETUP_LD;
          end else begin
            state_d   = STEP_LO;
            tmr_d     = LO_LD;
            cur_tap_d = tap_step(cur_tap_q, setn_q);
          end
        end else begin
          tmr_d = tmr_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = LOAD;
    endcase
  end

  // Output decode; the power-up load is internal and neither shows busy nor pulses done.
  always_comb begin
    sdtap_o   = 1'b1;
    value_o   = 1'b1;
    req_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      LOAD: begin
        sdtap_o = 1'b0;
        busy    = !pwrup_q;
      end
      IDLE:    req_ready = 1'b1;
      SETUP:   busy = 1'b1;
      STEP_LO: begin
        value_o = 1'b0;
        busy    = 1'b1;
      end
      STEP_HI: busy = 1'b1;
      DONE:    done = 1'b1;
      ERR:     err  = 1'b1;
      default: sdtap_o = 1'b0;
    endcase
  end

  assign setn_o  = setn_q;
  assign cur_tap = cur_tap_q;

endmodule
